set_assoc_cache_ctrl: RTL and testbench

SET_ASSOC_CACHE_CTRL -- requirements
Module: set_assoc_cache_ctrl

---
 rtl/set_assoc_cache_ctrl_if.sv | 28 ++
 rtl/set_assoc_cache_ctrl.sv | 156 +++++++++++++++
 tb/tb_set_assoc_cache_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/set_assoc_cache_ctrl_if.sv
// CPU request/response and backing-store signals of the 2-way cache controller.
// master = CPU plus backing store; slave = the cache controller.
interface set_assoc_cache_ctrl_if #(
    parameter int WORD_BITS = 1
);
    logic                          rd_en;
    logic                          wr_en;
    logic [31:0]                   addr;
    logic [31:0]                   wr_data;
    logic [31:0]                   rd_data;
    logic                          ready;
    logic                          sram_rd_en;
    logic                          sram_wr_en;
    logic [31:0]                   sram_addr;
    logic [31:0]                   sram_wr_data;
    logic                          sram_ready;
    logic [32*(2**WORD_BITS)-1:0]  sram_rd_data;

    modport master (
        output rd_en, wr_en, addr, wr_data, sram_ready, sram_rd_data,
        input  rd_data, ready, sram_rd_en, sram_wr_en, sram_addr, sram_wr_data
    );

    modport slave (
        input  rd_en, wr_en, addr, wr_data, sram_ready, sram_rd_data,
        output rd_data, ready, sram_rd_en, sram_wr_en, sram_addr, sram_wr_data
    );
endinterface

// File: rtl/set_assoc_cache_ctrl.sv
// 2-way set-associative write-through, no-write-allocate cache controller; CACHE_STATS_EN adds hit/miss counters.
// Latency: read hit same cycle; read miss / write complete in the cycle sram_ready is seen after the request cycle.
// Backpressure: CPU holds rd_en/wr_en until the one-cycle ready pulse; sram requests held until sram_ready.
module set_assoc_cache_ctrl #(
    parameter int SET_BITS  = 6,
    parameter int WORD_BITS = 1,
    parameter int TAG_W     = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    set_assoc_cache_ctrl_if.slave      bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                hit_count,
    output logic [31:0]                miss_count
`endif
);

    localparam int SETS   = 1 << SET_BITS;
    localparam int LINE_W = 32 << WORD_BITS;
    localparam int IDX_LO = 2 + WORD_BITS;
    localparam int TAG_LO = IDX_LO + SET_BITS;
    localparam int TAG_HI = TAG_LO + TAG_W;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << IDX_LO) - 32'd1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]      tag_q  [2][SETS];
    logic [LINE_W-1:0]     data_q [2][SETS];
    logic [1:0][SETS-1:0]  valid_q;
    logic [SETS-1:0]       lru_q;

    logic [WORD_BITS-1:0]  word_sel;
    logic [SET_BITS-1:0]   idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit0, hit1, hit, hit_way, victim;
    logic [LINE_W-1:0]     hit_line;
    logic [31:0]           hit_word, fill_word;
    logic                  fill_we, wr_hit_we, rd_hit;
    logic                  unused_addr;

    assign word_sel    = bus.addr[2 +: WORD_BITS];
    assign idx         = bus.addr[IDX_LO +: SET_BITS];
    assign tag         = bus.addr[TAG_LO +: TAG_W];
    assign unused_addr = ^{bus.addr[31:TAG_HI], bus.addr[1:0]};

    assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;

    // Prefer an empty way; only fall back to LRU when the set is full.
    assign victim = !valid_q[0][idx] ? 1'b0 :
                    !valid_q[1][idx] ? 1'b1 : lru_q[idx];

    assign hit_line  = data_q[hit_way][idx];
    assign hit_word  = hit_line[{word_sel, 5'd0} +: 32];
    assign fill_word = bus.sram_rd_data[{word_sel, 5'd0} +: 32];

    assign bus.sram_wr_data = bus.wr_data;
    assign bus.sram_addr    = ((state_q == WRITE) || (state_q == IDLE && bus.wr_en))
                              ? bus.addr : (bus.addr & LINE_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Outputs are gated by rst so an asserted reset silences the bus immediately.
    always_comb begin
        state_d        = state_q;
        bus.ready      = 1'b0;
        bus.rd_data    = '0;
        bus.sram_rd_en = 1'b0;
        bus.sram_wr_en = 1'b0;
        fill_we        = 1'b0;
        wr_hit_we      = 1'b0;
        rd_hit         = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.wr_en) begin
                        bus.sram_wr_en = 1'b1;
                        state_d        = WRITE;
                    end else if (bus.rd_en) begin
                        if (hit) begin
                            bus.ready   = 1'b1;
                            bus.rd_data = hit_word;
                            rd_hit      = 1'b1;
                        end else begin
                            bus.sram_rd_en = 1'b1;
                            state_d        = FILL;
                        end
                    end
                end
                FILL: begin
                    bus.sram_rd_en = 1'b1;
                    if (bus.sram_ready) begin
                        bus.ready   = 1'b1;
                        bus.rd_data = fill_word;
                        fill_we     = 1'b1;
                        state_d     = IDLE;
                    end
                end
                WRITE: begin
                    bus.sram_wr_en = 1'b1;
                    if (bus.sram_ready) begin
                        bus.ready = 1'b1;
                        wr_hit_we = hit;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            lru_q   <= '0;
        end else begin
            if (fill_we) begin
                valid_q[victim][idx] <= 1'b1;
                lru_q[idx]           <= ~victim;
            end else if (rd_hit || wr_hit_we) begin
                lru_q[idx] <= ~hit_way;
            end
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[victim][idx]  <= tag;
            data_q[victim][idx] <= bus.sram_rd_data;
        end else if (wr_hit_we) begin
            data_q[hit_way][idx][{word_sel, 5'd0} +: 32] <= bus.wr_data;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (rd_hit)  hit_count  <= hit_count + 32'd1;
            if (fill_we) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench for set_assoc_cache_ctrl: fills, hits, LRU eviction, write-through, reset abort, stats.
module tb_set_assoc_cache_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    set_assoc_cache_ctrl_if #(.WORD_BITS(1)) bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    set_assoc_cache_ctrl #(
        .SET_BITS  (6),
        .WORD_BITS (1),
        .TAG_W     (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave)
`ifdef CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one request; sram_ready rises once lat backing-store cycles have elapsed.
    task automatic do_req(input string tag, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [63:0] line, input int lat,
                          output logic [31:0] data, output int rcyc,
                          output int wcyc, output logic [31:0] saddr);
        int cnt;
        bit done;
        bit stray;
        @(negedge clk);
        bus.rd_en        = rd;
        bus.wr_en        = wr;
        bus.addr         = a;
        bus.wr_data      = d;
        bus.sram_rd_data = line;
        cnt = 0; rcyc = 0; wcyc = 0; done = 0; stray = 0;
        data = '0; saddr = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            bus.sram_ready = (cnt == lat);
            #1;
            if (bus.sram_rd_en) rcyc++;
            if (bus.sram_wr_en) wcyc++;
            if (bus.sram_rd_en || bus.sram_wr_en) begin
                cnt++;
                saddr = bus.sram_addr;
            end
            if (bus.ready) begin
                data = bus.rd_data;
                done = 1;
            end else if (bus.rd_data != 32'd0) begin
                stray = 1;
            end
            @(negedge clk);
        end
        bus.rd_en      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.sram_ready = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_rdata_idle0"}, stray, 0);
        #1;
        chk({tag, "_ready_pulse"}, bus.ready, 0);
    endtask

    logic [31:0] data, saddr;
    int          rcyc, wcyc;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = '0; bus.wr_data = '0;
        bus.sram_ready = 1'b0; bus.sram_rd_data = '0;

        // Reset: a pending read miss must not reach the bus.
        bus.rd_en = 1'b1; bus.addr = 32'h0000_0104;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", bus.ready, 0);
        chk("rst_sram_rd_en", bus.sram_rd_en, 0);
        chk("rst_sram_wr_en", bus.sram_wr_en, 0);
        @(negedge clk);
        bus.rd_en = 1'b0;
        rst = 1'b0;

        // Idle with sram_ready high must not complete anything.
        @(negedge clk);
        bus.sram_ready = 1'b1;
        #1 chk("idle_sram_ready", bus.ready, 0);
        @(negedge clk);
        #1 chk("idle_sram_ready2", bus.ready, 0);
        bus.sram_ready = 1'b0;

        // Miss fill then hit on the other word of the line.
        do_req("miss104", 1, 0, 32'h104, 0, 64'h2222_2222_1111_1111, 3, data, rcyc, wcyc, saddr);
        chk("miss104_data", data, 32'h2222_2222);
        chk("miss104_rcyc", rcyc, 4);
        chk("miss104_saddr", saddr, 32'h100);
        do_req("hit100", 1, 0, 32'h100, 0, 64'h0, 3, data, rcyc, wcyc, saddr);
        chk("hit100_data", data, 32'h1111_1111);
        chk("hit100_rcyc", rcyc, 0);

        // Set 0: tags 0,1,2; 0x400 evicts 0x000, refill of 0x000 evicts LRU 0x200.
        do_req("f000", 1, 0, 32'h000, 0, 64'hA1A1_A1A1_A0A0_A0A0, 1, data, rcyc, wcyc, saddr);
        do_req("f200", 1, 0, 32'h200, 0, 64'hB1B1_B1B1_B0B0_B0B0, 1, data, rcyc, wcyc, saddr);
        chk("f200_data", data, 32'hB0B0_B0B0);
        do_req("f400", 1, 0, 32'h400, 0, 64'hC1C1_C1C1_C0C0_C0C0, 1, data, rcyc, wcyc, saddr);
        do_req("r000", 1, 0, 32'h000, 0, 64'hA1A1_A1A1_A0A0_A0A0, 1, data, rcyc, wcyc, saddr);
        chk("r000_miss", rcyc, 2);
        chk("r000_data", data, 32'hA0A0_A0A0);
        do_req("r400", 1, 0, 32'h400, 0, 64'h0, 1, data, rcyc, wcyc, saddr);
        chk("r400_hit", rcyc, 0);
        chk("r400_data", data, 32'hC0C0_C0C0);
        do_req("r200", 1, 0, 32'h200, 0, 64'hB1B1_B1B1_B0B0_B0B0, 1, data, rcyc, wcyc, saddr);
        chk("r200_miss", rcyc, 2);
        // 0x400 was made MRU by its hit, so the 0x200 refill took 0x000's way.
        do_req("r400b", 1, 0, 32'h404, 0, 64'h0, 1, data, rcyc, wcyc, saddr);
        chk("r400b_hit", rcyc, 0);
        chk("r400b_data", data, 32'hC1C1_C1C1);

        // Write-through hit on 0x104.
        do_req("w104", 0, 1, 32'h104, 32'hDEAD_BEEF, 64'h0, 2, data, rcyc, wcyc, saddr);
        chk("w104_wcyc", wcyc, 3);
        chk("w104_rcyc", rcyc, 0);
        chk("w104_saddr", saddr, 32'h104);
        chk("w104_wdata", bus.sram_wr_data, 32'hDEAD_BEEF);
        do_req("r104", 1, 0, 32'h104, 0, 64'h0, 1, data, rcyc, wcyc, saddr);
        chk("r104_hit", rcyc, 0);
        chk("r104_data", data, 32'hDEAD_BEEF);

        // Write miss does not allocate.
        do_req("w800", 0, 1, 32'h800, 32'h1234_5678, 64'h0, 1, data, rcyc, wcyc, saddr);
        chk("w800_wcyc", wcyc, 2);
        do_req("r800", 1, 0, 32'h800, 0, 64'hE1E1_E1E1_E0E0_E0E0, 1, data, rcyc, wcyc, saddr);
        chk("r800_miss", rcyc, 2);
        chk("r800_data", data, 32'hE0E0_E0E0);

        // Simultaneous read and write: write path only.
        do_req("rw100", 1, 1, 32'h100, 32'hCAFE_F00D, 64'h0, 1, data, rcyc, wcyc, saddr);
        chk("rw100_rcyc", rcyc, 0);
        chk("rw100_wcyc", wcyc, 2);
        chk("rw100_saddr", saddr, 32'h100);
        do_req("r100", 1, 0, 32'h100, 0, 64'h0, 1, data, rcyc, wcyc, saddr);
        chk("r100_data", data, 32'hCAFE_F00D);
        do_req("r104b", 1, 0, 32'h104, 0, 64'h0, 1, data, rcyc, wcyc, saddr);
        chk("r104b_data", data, 32'hDEAD_BEEF);

        // Reset during the second FILL cycle abandons the fill.
        @(negedge clk);
        bus.rd_en = 1'b1; bus.addr = 32'h1010; bus.sram_rd_data = 64'h4444_4444_3333_3333;
        #1 chk("abort_c0_rd_en", bus.sram_rd_en, 1);
        @(negedge clk);
        #1 chk("abort_c1_rd_en", bus.sram_rd_en, 1);
        @(negedge clk);
        bus.sram_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("abort_rd_en_drop", bus.sram_rd_en, 0);
        chk("abort_ready", bus.ready, 0);
        @(negedge clk);
        rst = 1'b0; bus.rd_en = 1'b0; bus.sram_ready = 1'b0;
        do_req("r1010", 1, 0, 32'h1010, 0, 64'h4444_4444_3333_3333, 2, data, rcyc, wcyc, saddr);
        chk("r1010_miss", rcyc, 3);
        chk("r1010_data", data, 32'h3333_3333);
        do_req("h1010", 1, 0, 32'h1010, 0, 64'h0, 1, data, rcyc, wcyc, saddr);
        do_req("h1014", 1, 0, 32'h1014, 0, 64'h0, 1, data, rcyc, wcyc, saddr);
        chk("h1014_data", data, 32'h4444_4444);
        do_req("h1010b", 1, 0, 32'h1010, 0, 64'h0, 1, data, rcyc, wcyc, saddr);
        chk("h1010b_hit", rcyc, 0);
        do_req("m2010", 1, 0, 32'h2010, 0, 64'h6666_6666_5555_5555, 1, data, rcyc, wcyc, saddr);
        chk("m2010_miss", rcyc, 2);
`ifdef CACHE_STATS_EN
        chk("hit_count", hit_count, 3);
        chk("miss_count", miss_count, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
